// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: schedules a single-port SRAM between camera pixel writes
// (buffered in a small FIFO) and VGA scan-out reads (strict priority), with a
// bus-turnaround idle cycle inserted between a write and a following read.
module sram_port_arbiter #(
    parameter int AW         = 20,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    // camera write side
    input  logic                          wr_push,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [DW-1:0]                 wr_data,
    output logic                          wr_full,
    output logic [$clog2(FIFO_DEPTH):0]   wr_level,
    output logic [15:0]                   wr_drop_cnt,
    // VGA read side
    input  logic                          rd_req,
    input  logic [AW-1:0]                 rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic [DW-1:0]                 rd_data,
    // controller command / response
    output logic [AW-1:0]                 sram_address,
    output logic                          sram_read,
    output logic                          sram_write,
    output logic [DW-1:0]                 sram_writedata,
    input  logic [DW-1:0]                 sram_readdata,
    input  logic                          sram_readdatavalid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // State names the command issued in the current cycle.
    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_mem [FIFO_DEPTH];
    logic [DW-1:0]   data_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]   count_reg;
    logic [15:0]     drop_cnt_reg;
    logic [2:0]      outstanding_reg;
    logic            pop;
    logic            push_ok;
    logic            rsp_counted;

    // A read may go out in any cycle except right after a write (turnaround).
    assign rd_gnt      = rd_req && (state_reg != WRITE);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok     = wr_push && ((count_reg < LW'(FIFO_DEPTH)) || pop);
    // Responses with no read in flight are stray and must not surface.
    assign rsp_counted = sram_readdatavalid && (outstanding_reg != 3'd0);

    assign wr_full     = (count_reg == LW'(FIFO_DEPTH));
    assign wr_level    = count_reg;
    assign wr_drop_cnt = drop_cnt_reg;

    // Next-command selection: read first, then turnaround, then buffered write.
    always_comb begin
        state_next = IDLE;
        pop        = 1'b0;
        if (rd_gnt) begin
            state_next = READ;
        end else if (rd_req) begin
            state_next = TURN;
        end else if ((state_reg != TURN) && (count_reg != '0)) begin
            state_next = WRITE;
            pop        = 1'b1;
        end
    end

    // State and registered command towards the controller.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            sram_read      <= 1'b0;
            sram_write     <= 1'b0;
            sram_address   <= '0;
            sram_writedata <= '0;
        end else begin
            state_reg  <= state_next;
            sram_read  <= (state_next == READ);
            sram_write <= (state_next == WRITE);
            if (state_next == READ) begin
                sram_address <= rd_addr;
            end else if (pop) begin
                sram_address   <= addr_mem[rd_ptr_reg];
                sram_writedata <= data_mem[rd_ptr_reg];
            end
        end
    end

    // FIFO storage: no reset so it maps onto plain RAM.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr_reg] <= wr_addr;
            data_mem[wr_ptr_reg] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push_ok && !pop) begin
                count_reg <= count_reg + LW'(1);
            end else if (pop && !push_ok) begin
                count_reg <= count_reg - LW'(1);
            end
            if (wr_push && !push_ok && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    // Outstanding-read tracking and one-cycle registered read return.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            outstanding_reg <= 3'd0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + {2'b00, rd_gnt} - {2'b00, rsp_counted};
            rd_valid        <= rsp_counted;
            if (rsp_counted) begin
                rd_data <= sram_readdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based reference model of the scheduler.
module tb_sram_port_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            wr_push;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_full;
    logic [LW-1:0]   wr_level;
    logic [15:0]     wr_drop_cnt;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_gnt;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [AW-1:0]   sram_address;
    logic            sram_read;
    logic            sram_write;
    logic [DW-1:0]   sram_writedata;
    logic [DW-1:0]   sram_readdata;
    logic            sram_readdatavalid;

    always #10 Clk = ~Clk;

    sram_port_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(D)) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .wr_push            (wr_push),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_full            (wr_full),
        .wr_level           (wr_level),
        .wr_drop_cnt        (wr_drop_cnt),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_gnt             (rd_gnt),
        .rd_valid           (rd_valid),
        .rd_data            (rd_data),
        .sram_address       (sram_address),
        .sram_read          (sram_read),
        .sram_write         (sram_write),
        .sram_writedata     (sram_writedata),
        .sram_readdata      (sram_readdata),
        .sram_readdatavalid (sram_readdatavalid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t            q[$];
    int              last_cmd = 0;   // 0 none, 1 read, 2 write, 3 turnaround
    int              drop     = 0;
    int              outst    = 0;
    bit              granted  = 0;
    logic            e_read = 0, e_write = 0, e_valid = 0;
    logic [AW-1:0]   e_addr = '0;
    logic [DW-1:0]   e_wdata = '0, e_rdata = '0;

    // One clock: check combinational/occupancy at negedge, advance model at
    // posedge, check registered outputs 1 time unit later.
    task automatic cycle();
        bit   e_gnt, pop, acc;
        ent_t e;
        @(negedge Clk);
        e_gnt = rd_req && (last_cmd != 2);
        check("rd_gnt", 32'(rd_gnt), 32'(e_gnt));
        check("wr_level", 32'(wr_level), 32'(q.size()));
        check("wr_full", 32'(wr_full), 32'(q.size() == D));
        check("wr_drop_cnt", 32'(wr_drop_cnt), 32'(drop));
        @(posedge Clk);
        if (Reset) begin
            q.delete();
            last_cmd = 0; drop = 0; outst = 0;
            e_read = 0; e_write = 0; e_valid = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else begin
            pop = !rd_req && (last_cmd != 3) && (q.size() > 0);
            acc = (q.size() < D) || pop;
            e_read  = 0;
            e_write = 0;
            if (e_gnt) begin
                last_cmd = 1; e_read = 1; e_addr = rd_addr;
            end else if (rd_req) begin
                last_cmd = 3;
            end else if (pop) begin
                last_cmd = 2; e_write = 1; e_addr = q[0].a; e_wdata = q[0].d;
            end else begin
                last_cmd = 0;
            end
            if (pop) void'(q.pop_front());
            if (wr_push) begin
                if (acc) begin
                    e.a = wr_addr; e.d = wr_data;
                    q.push_back(e);
                end else if (drop < 65535) begin
                    drop++;
                end
            end
            e_valid = sram_readdatavalid && (outst > 0);
            if (e_valid) e_rdata = sram_readdata;
            outst = (outst + int'(e_gnt) - int'(e_valid)) % 8;
        end
        granted = e_gnt;
        #1;
        check("sram_read", 32'(sram_read), 32'(e_read));
        check("sram_write", 32'(sram_write), 32'(e_write));
        if (e_read || e_write) check("sram_address", 32'(sram_address), 32'(e_addr));
        if (e_write) check("sram_writedata", 32'(sram_writedata), 32'(e_wdata));
        check("rd_valid", 32'(rd_valid), 32'(e_valid));
        if (e_valid) check("rd_data", 32'(rd_data), 32'(e_rdata));
        if (e_write) $display("write addr=%05h data=%04h", e_addr, e_wdata);
        if (e_read)  $display("read  addr=%05h", e_addr);
        if (e_valid) $display("rdrsp data=%04h", e_rdata);
    endtask

    task automatic quiet(input int n);
        wr_push = 0; rd_req = 0; sram_readdatavalid = 0; Reset = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        Reset = 1; wr_push = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0; sram_readdata = '0; sram_readdatavalid = 0;

        // reset
        cycle(); cycle();
        Reset = 0;
        check("reset_level", 32'(wr_level), 32'd0);
        check("reset_drop", 32'(wr_drop_cnt), 32'd0);
        check("reset_cmd", 32'({sram_read, sram_write, rd_valid}), 32'd0);

        // four pushes drain back to back
        for (int i = 0; i < 4; i++) begin
            wr_push = 1; wr_addr = AW'(20'h00010 + i); wr_data = DW'(16'hA000 + i);
            cycle();
        end
        quiet(6);
        check("drain_level", 32'(wr_level), 32'd0);

        // write in progress, then read: one turnaround cycle
        wr_push = 1; wr_addr = 20'h00100; wr_data = 16'h1111; cycle();
        wr_push = 1; wr_addr = 20'h00101; wr_data = 16'h2222; cycle();
        check("write_started", 32'(sram_write), 32'd1);
        wr_push = 0; rd_req = 1; rd_addr = 20'h12345; cycle();
        check("turn_no_cmd", 32'({sram_read, sram_write}), 32'd0);
        cycle();
        check("read_after_turn", 32'(sram_read), 32'd1);
        check("read_addr", 32'(sram_address), 32'h12345);
        rd_req = 0; cycle();
        check("write_after_read", 32'(sram_writedata), 32'h2222);

        // read response latency
        sram_readdatavalid = 1; sram_readdata = 16'hBEEF; cycle();
        check("rsp_valid", 32'(rd_valid), 32'd1);
        check("rsp_data", 32'(rd_data), 32'hBEEF);
        sram_readdatavalid = 0; cycle();

        // held read starves writes; FIFO fills and drops
        rd_req = 1; rd_addr = 20'h00777; sram_readdatavalid = 1; sram_readdata = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            wr_push = 1; wr_addr = AW'(20'h00200 + i); wr_data = DW'(16'hC000 + i);
            cycle();
        end
        check("full_after_10", 32'(wr_full), 32'd1);
        check("drop_after_10", 32'(wr_drop_cnt), 32'd2);
        // push at full while the head pops
        rd_req = 0; sram_readdatavalid = 0; wr_push = 1;
        wr_addr = 20'h00300; wr_data = 16'hD000; cycle();
        check("full_push_pop_level", 32'(wr_level), 32'd8);
        check("full_push_pop_drop", 32'(wr_drop_cnt), 32'd2);
        quiet(12);
        check("drained", 32'(wr_level), 32'd0);

        // reads in flight are discarded by reset
        rd_req = 1; rd_addr = 20'h00400; cycle();
        rd_addr = 20'h00401; cycle();
        rd_req = 0; Reset = 1; cycle();
        Reset = 0; sram_readdatavalid = 1; sram_readdata = 16'h1234; cycle();
        check("stale_rsp_0", 32'(rd_valid), 32'd0);
        cycle();
        check("stale_rsp_1", 32'(rd_valid), 32'd0);
        sram_readdatavalid = 0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = (i / 500) % 2 == 0 ? 20 : 60;
            Reset   = ($urandom_range(0, 249) == 0);
            wr_push = ($urandom_range(0, 99) < 55);
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            if (!(rd_req && !granted)) begin
                rd_req  = ($urandom_range(0, 99) < rd_pct);
                rd_addr = AW'($urandom);
            end
            sram_readdatavalid = ($urandom_range(0, 99) < 35);
            sram_readdata      = DW'($urandom);
            cycle();
        end
        quiet(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
